// File: rtl/v_instr_queue.sv
// v_instr_queue: FIFO buffering vector instructions with rs1/rs2 and a SEW stamp
// tracked by snooping vset{i}vl{i} at push time.
module v_instr_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_instr_vld_i,
  input  logic [31:0]      s_instr_i,
  input  logic [31:0]      s_rs1_i,
  input  logic [31:0]      s_rs2_i,
  output logic             s_instr_rdy_o,
  input  logic             flush_i,
  output logic [31:0]      sched_instr_o,
  output logic [31:0]      sched_rs1_o,
  output logic [31:0]      sched_rs2_o,
  output logic [1:0]       sched_sew_o,
  input  logic             sched_stall_i,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] instr_q [DEPTH];
  logic [31:0] rs1_q [DEPTH];
  logic [31:0] rs2_q [DEPTH];
  logic [1:0] sew_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0] sew_reg, new_sew, stamp;
  logic push, pop, is_vset;
  assign count_o = count;
  assign empty_o = count == '0;
  assign s_instr_rdy_o = count != CNT_W'(DEPTH);
  assign push = s_instr_vld_i && s_instr_rdy_o;
  assign pop = !empty_o && !sched_stall_i;
  assign is_vset = s_instr_i[6:0] == 7'b1010111 && s_instr_i[14:12] == 3'b111;
  // only vsetvl (bits 31:30 = 10) takes SEW from rs2; immediate forms use vtype[4:3]
  assign new_sew = s_instr_i[31:30] == 2'b10 ? s_rs2_i[4:3] : s_instr_i[24:23];
  assign stamp = is_vset ? new_sew : sew_reg;
  assign sched_instr_o = empty_o ? '0 : instr_q[rd_ptr];
  assign sched_rs1_o = empty_o ? '0 : rs1_q[rd_ptr];
  assign sched_rs2_o = empty_o ? '0 : rs2_q[rd_ptr];
  assign sched_sew_o = empty_o ? '0 : sew_q[rd_ptr];
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      instr_q[wr_ptr] <= s_instr_i;
      rs1_q[wr_ptr] <= s_rs1_i;
      rs2_q[wr_ptr] <= s_rs2_i;
      sew_q[wr_ptr] <= stamp;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      sew_reg <= 2'b00;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && is_vset) sew_reg <= new_sew;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_v_instr_queue.sv
// tb_v_instr_queue: directed table, hand sequences and random traffic checked
// against a queue-based reference model.
module tb_v_instr_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  logic clk = 0, rstn = 0, vld = 0, flush = 0, stall = 0;
  logic [31:0] instr = 0, rs1 = 0, rs2 = 0;
  logic rdy, empty;
  logic [31:0] s_instr, s_rs1, s_rs2;
  logic [1:0] s_sew;
  logic [CNT_W-1:0] count;
  int nvec = 0, nerr = 0;

  typedef struct {logic [31:0] instr, rs1, rs2; logic [1:0] sew;} ent_t;
  ent_t q[$];
  logic [1:0] m_sew = 0;

  typedef struct {
    logic v; logic [31:0] i, r1, r2; logic st, fl;
    logic [31:0] e_instr, e_rs1; logic [1:0] e_sew; int e_cnt;
  } vec_t;
  vec_t tbl[13];

  v_instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .s_instr_vld_i(vld), .s_instr_i(instr),
    .s_rs1_i(rs1), .s_rs2_i(rs2), .s_instr_rdy_o(rdy), .flush_i(flush),
    .sched_instr_o(s_instr), .sched_rs1_o(s_rs1), .sched_rs2_o(s_rs2),
    .sched_sew_o(s_sew), .sched_stall_i(stall), .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] sew_of(input logic [31:0] i, input logic [31:0] r2);
    // bit 2 flags a vset; bits 1:0 carry the SEW it selects
    if (i[6:0] != 7'h57 || i[14:12] != 3'b111) return 3'b000;
    if (i[31] == 1'b0 || i[30] == 1'b1) return {1'b1, i[24:23]};
    return {1'b1, r2[4:3]};
  endfunction

  task automatic check_model(input string tag);
    ent_t h;
    h = q.size() ? q[0] : '{0, 0, 0, 0};
    nvec++;
    if (rdy !== (q.size() != DEPTH) || empty !== (q.size() == 0) || count !== CNT_W'(q.size())
        || s_instr !== h.instr || s_rs1 !== h.rs1 || s_rs2 !== h.rs2 || s_sew !== h.sew) begin
      nerr++;
      $display("FAIL %s: got rdy=%b empty=%b cnt=%0d instr=%h rs1=%h rs2=%h sew=%0d; want rdy=%b empty=%b cnt=%0d instr=%h rs1=%h rs2=%h sew=%0d",
               tag, rdy, empty, count, s_instr, s_rs1, s_rs2, s_sew,
               q.size() != DEPTH, q.size() == 0, q.size(), h.instr, h.rs1, h.rs2, h.sew);
    end
  endtask

  task automatic expect1(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] i, r1, r2, input logic st, fl, input string tag);
    logic do_push, do_pop;
    logic [2:0] s;
    vld = v; instr = i; rs1 = r1; rs2 = r2; stall = st; flush = fl;
    @(posedge clk);
    do_push = v && q.size() < DEPTH;
    do_pop = q.size() != 0 && !st;
    s = sew_of(i, r2);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (s[2]) m_sew = s[1:0];
        q.push_back('{i, r1, r2, m_sew});
      end
    end
    #1 check_model(tag);
  endtask

  initial begin
    tbl[0]  = '{1, 32'h022100D7, 5, 7, 0, 0, 32'h022100D7, 5, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 32'h00001057, 1, 0, 1, 0, 32'h00001057, 1, 0, 1};
    tbl[3]  = '{1, 32'h01007057, 2, 0, 1, 0, 32'h00001057, 1, 0, 2};
    tbl[4]  = '{1, 32'h02006007, 3, 0, 1, 0, 32'h00001057, 1, 0, 3};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 32'h01007057, 2, 2, 2};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 32'h02006007, 3, 2, 1};
    tbl[7]  = '{1, 32'h80007057, 4, 32'h18, 1, 0, 32'h02006007, 3, 2, 2};
    tbl[8]  = '{1, 32'h00001057, 5, 0, 0, 0, 32'h80007057, 4, 3, 2};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 32'h00001057, 5, 3, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 32'hC0807057, 6, 0, 1, 0, 32'hC0807057, 6, 1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    #1 check_model("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1;

    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].i, tbl[k].r1, tbl[k].r2, tbl[k].st, tbl[k].fl, $sformatf("tbl%0d", k));
      nvec++;
      if (s_instr !== tbl[k].e_instr || s_rs1 !== tbl[k].e_rs1 || s_sew !== tbl[k].e_sew || count !== CNT_W'(tbl[k].e_cnt)) begin
        nerr++;
        $display("FAIL tbl%0d_exp: got instr=%h rs1=%h sew=%0d cnt=%0d want instr=%h rs1=%h sew=%0d cnt=%0d",
                 k, s_instr, s_rs1, s_sew, count, tbl[k].e_instr, tbl[k].e_rs1, tbl[k].e_sew, tbl[k].e_cnt);
      end
    end

    for (int k = 0; k < DEPTH; k++) step(1, 32'h00001057 | (k << 20), 32'h100 + k, k, 1, 0, "fill");
    expect1("full_cnt", 32'(count), DEPTH);
    expect1("full_rdy", 32'(rdy), 0);
    step(1, 32'h0000A057, 32'hBAD, 0, 1, 0, "fifth_offer");
    expect1("fifth_cnt", 32'(count), DEPTH);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, 0, 0, "drain");
    for (int k = 0; k < DEPTH; k++) step(1, 32'h00002057 | (k << 20), k, k, 1, 0, "refill");
    step(1, 32'h01807057, 32'hF1, 0, 1, 1, "flush_push");
    expect1("flush_empty", 32'(empty), 1);
    expect1("flush_instr", s_instr, 0);
    step(1, 32'h00003057, 9, 9, 1, 0, "post_flush");
    expect1("flush_sew_kept", 32'(s_sew), 1);
    step(0, 0, 0, 0, 0, 0, "post_flush_pop");

    for (int c = 0; c < 4 * DEPTH; c++)
      step(1, $urandom, $urandom, $urandom, c[0], 0, "stream");

    for (int c = 0; c < 300; c++) begin
      logic [31:0] ri;
      ri = $urandom;
      if ($urandom_range(3) == 0) ri = {ri[31:15], 3'b111, ri[11:7], 7'h57};
      if (c == 150) begin
        vld = 1; stall = 1;
        #2 rstn = 0;
        #1;
        expect1("arst_cnt", 32'(count), 0);
        expect1("arst_empty", 32'(empty), 1);
        expect1("arst_rdy", 32'(rdy), 1);
        expect1("arst_sched", s_instr | s_rs1 | s_rs2 | 32'(s_sew), 0);
        q.delete();
        m_sew = 0;
        @(negedge clk) rstn = 1;
      end
      step($urandom_range(1), ri, $urandom, $urandom, $urandom_range(1), $urandom_range(15) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/v_instr_queue.md
Name: v_instr_queue

Overview:
- Decoupling FIFO between the scalar core's vector-issue port and the vector scheduler.
- Buffers vector instructions together with their scalar operands rs1/rs2, so the scalar pipeline stalls only when the queue is full, not on every scheduler stall.
- Tracks the architectural SEW by snooping vset{i}vl{i} at push time and stamps each entry with it.
- Drives the scheduler's instruction, rs1, rs2 and sew inputs; presents instruction 0 (no-op) when empty.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_instr_vld_i  in  1  scalar core offers an instruction this cycle.
- s_instr_i  in  32  vector instruction word.
- s_rs1_i  in  32  scalar rs1 value.
- s_rs2_i  in  32  scalar rs2 value.
- s_instr_rdy_o  out  1  queue can accept (not full).
- flush_i  in  1  synchronous flush of all queued entries.
- sched_instr_o  out  32  head instruction to scheduler; 32'h0 when empty.
- sched_rs1_o  out  32  head rs1; 0 when empty.
- sched_rs2_o  out  32  head rs2; 0 when empty.
- sched_sew_o  out  2  SEW stamped on head entry; 0 when empty.
- sched_stall_i  in  1  scheduler stall; head is not consumed while high.
- empty_o  out  1  queue empty.
- count_o  out  CNT_W  occupancy.

Behaviour:
- Reset (async, rstn=0):
  - wr_ptr = rd_ptr = 0, count = 0, sew_reg = 2'b00.
  - Outputs: s_instr_rdy_o=1, empty_o=1, count_o=0, all sched_* = 0.
  - Reset asserted mid-operation discards all entries immediately.
- Push:
  - Occurs when s_instr_vld_i && s_instr_rdy_o at the rising edge.
  - Stores {instr, rs1, rs2, sew_stamp} at wr_ptr; wr_ptr wraps modulo DEPTH.
- s_instr_rdy_o = (count != DEPTH).
  - No combinational dependence on sched_stall_i.
  - A push while full is not possible, even with a simultaneous pop.
- Pop:
  - Occurs when !empty && !sched_stall_i at the rising edge.
  - rd_ptr wraps modulo DEPTH.
  - sched_stall_i is ignored while empty.
- Head outputs are combinational from the entry at rd_ptr; all zero when empty.
- Latency: an instruction pushed into an empty queue appears on sched_* one cycle later. There is no bypass path.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- SEW tracking:
  - An instruction is a vset when opcode = 7'b1010111 and funct3 = 3'b111.
  - new_sew:
    - instr[31]=0 (vsetvli): instr[24:23].
    - instr[31:30]=11 (vsetivli): instr[24:23].
    - instr[31:30]=10 (vsetvl): rs2[4:3].
  - On a push of a vset: sew_reg <= new_sew, and the entry is stamped with new_sew.
  - Other pushes are stamped with the current sew_reg.
  - vsew[2] is ignored; only 2-bit SEW (e8..e64) is supported.
- flush_i:
  - Next edge: count=0, wr_ptr=rd_ptr=0.
  - sew_reg is retained.
  - Flush has priority over push and pop in the same cycle; the pushed entry is dropped.
- Occupancy: count_o and empty_o are registered state. empty_o = (count == 0).

Test Plan:
1. Reset, then push addi-free vadd.vv 32'h0221_00D7 with rs1=5, rs2=7 and sched_stall_i=0 → cycle+1: sched_instr_o=32'h022100D7, sched_rs1_o=5, sched_sew_o=0; cycle+2: empty_o=1, sched_instr_o=0.
2. Hold sched_stall_i=1 and push 4 instructions back-to-back → count_o=4, s_instr_rdy_o=0 on the cycle after the 4th push; a 5th offer is not accepted. Release the stall → entries drain in push order, one per cycle.
3. Push vsetvli with instr[24:23]=2'b10, then vle32 → both entries carry sched_sew_o=2; an earlier queued entry keeps sew=0.
4. Push vsetvl (instr[31:30]=10) with rs2=32'h18 → new_sew=rs2[4:3]=2'b11; the following entries are stamped 3.
5. Full queue with stall=1, assert flush_i together with s_instr_vld_i → next cycle count_o=0, empty_o=1, sched_instr_o=0, pushed entry absent; sew_reg unchanged.
6. Steady state with a push every cycle and stall toggling 1/0 → no loss or duplication across pointer wrap (≥3×DEPTH entries, scoreboard order check). Assert rstn low mid-stream → all outputs return to reset values immediately.
